// File: rtl/fifo_stream_reader_if.sv
// FIFO drain-side and output stream signals of fifo_stream_reader.
// master = the reader; slave = the FIFO plus the downstream consumer.
// Optional FIFO_RD_PARITY_EN adds m_par next to m_data.
interface fifo_stream_reader_if #(
  parameter int DATA_W = 8
);
  logic              fifo_empty;
  logic              fifo_pop;
  logic [DATA_W-1:0] fifo_data;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_last;
`ifdef FIFO_RD_PARITY_EN
  logic              m_par;
`endif

  modport master (
    output fifo_pop, m_valid, m_data, m_last,
`ifdef FIFO_RD_PARITY_EN
    output m_par,
`endif
    input  fifo_empty, fifo_data, m_ready
  );

  modport slave (
    input  fifo_pop, m_valid, m_data, m_last,
`ifdef FIFO_RD_PARITY_EN
    input  m_par,
`endif
    output fifo_empty, fifo_data, m_ready
  );
endinterface

// File: rtl/fifo_stream_reader.sv
// Drains a registered-read push/pop FIFO into a valid/ready stream framed in
// BURST_LEN-word bursts. A 2-entry holding buffer (output + skid register) and
// a credit check on pops guarantee the block never pops more than it can hold.
// Optional FIFO_RD_PARITY_EN: m_par = XOR of m_data, stored per buffer entry.
module fifo_stream_reader #(
  parameter int DATA_W    = 8,
  parameter int BURST_LEN = 4,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  fifo_stream_reader_if.master bus,
  output logic                 busy,
  output logic [CNT_W-1:0]     frames_done
);
  localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BW-1:0] LAST_IDX = BW'(BURST_LEN - 1);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
`ifdef FIFO_RD_PARITY_EN
    logic              par;
`endif
  } entry_t;

  state_t        state_q, state_d;
  logic          pop_allowed;
  logic [1:0]    occ_q;
  logic          inflight_q;
  logic [BW-1:0] issue_cnt, beat_cnt;
  entry_t        out_q, skid_q, cap;
  logic          accept, pop;
  logic [1:0]    level;

  assign accept = bus.m_valid && bus.m_ready;
  // Words committed after this cycle: buffered + in flight - leaving now.
  assign level  = occ_q + 2'(inflight_q) - 2'(accept);
  assign pop    = pop_allowed && !bus.fifo_empty && (level < 2'd2);

  assign bus.fifo_pop = pop;
  assign bus.m_valid  = (occ_q != 2'd0);
  assign bus.m_data   = out_q.data;
  assign bus.m_last   = bus.m_valid && (beat_cnt == LAST_IDX);
`ifdef FIFO_RD_PARITY_EN
  assign bus.m_par    = out_q.par;
`endif
  assign busy = (state_q != IDLE);

  // Shape the captured FIFO word into a buffer entry.
  always_comb begin
    cap      = '0;
    cap.data = bus.fifo_data;
`ifdef FIFO_RD_PARITY_EN
    cap.par  = ^bus.fifo_data;
`endif
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next state and pop permission; FINISH only pops to close the open frame.
  always_comb begin
    state_d     = state_q;
    pop_allowed = 1'b0;
    case (state_q)
      IDLE: if (enable) state_d = RUN;
      RUN: begin
        pop_allowed = 1'b1;
        if (!enable) state_d = FINISH;
      end
      FINISH: begin
        pop_allowed = (issue_cnt != '0);
        if (issue_cnt == '0 && !inflight_q && occ_q == 2'd0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Holding buffer: captures land in the output register when it frees up
  // this cycle, otherwise in the skid register; skid refills output on accept.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_q      <= '0;
      skid_q     <= '0;
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= pop;
      occ_q      <= occ_q + 2'(inflight_q) - 2'(accept);
      if (accept && occ_q == 2'd2)
        out_q <= skid_q;
      else if (inflight_q && (occ_q == 2'd0 || accept))
        out_q <= cap;
      if (inflight_q && occ_q != 2'd0 && !accept)
        skid_q <= cap;
    end
  end

  // Frame position of pops and accepted beats, plus completed-frame count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      issue_cnt   <= '0;
      beat_cnt    <= '0;
      frames_done <= '0;
    end else begin
      if (pop)
        issue_cnt <= (issue_cnt == LAST_IDX) ? '0 : issue_cnt + 1'b1;
      if (accept) begin
        beat_cnt <= (beat_cnt == LAST_IDX) ? '0 : beat_cnt + 1'b1;
        if (bus.m_last) frames_done <= frames_done + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_fifo_stream_reader.sv
// Randomized and directed bench for fifo_stream_reader. A queue-based FIFO
// model feeds the DUT; a scoreboard of popped words checks order, framing,
// stall stability and the 2-word outstanding limit.
module tb_fifo_stream_reader;
  localparam int DATA_W = 8;
  localparam int BL     = 4;
  localparam int CNT_W  = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic enable = 1'b0;
  logic busy;
  logic [CNT_W-1:0] frames_done;

  fifo_stream_reader_if #(.DATA_W(DATA_W)) bus();

  fifo_stream_reader #(.DATA_W(DATA_W), .BURST_LEN(BL), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .enable(enable), .bus(bus),
    .busy(busy), .frames_done(frames_done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // FIFO model: registered read data and registered empty flag.
  logic [DATA_W-1:0] fifo_q[$];
  logic [DATA_W-1:0] push_pend[$];
  logic [DATA_W-1:0] fifo_data_r = '0;
  logic              fifo_empty_r = 1'b1;
  logic              pop_pend = 1'b0;
  logic              m_ready = 1'b0;
  assign bus.fifo_data  = fifo_data_r;
  assign bus.fifo_empty = fifo_empty_r;
  assign bus.m_ready    = m_ready;

  always @(posedge clk) begin
    if (pop_pend && fifo_q.size() > 0) fifo_data_r <= fifo_q.pop_front();
    foreach (push_pend[i]) fifo_q.push_back(push_pend[i]);
    push_pend.delete();
    fifo_empty_r <= (fifo_q.size() == 0);
  end

  // Scoreboard state.
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] acc_data[$];
  logic              acc_last[$];
  int beats = 0, frames = 0, pops = 0, n_acc = 0, cyc = 0;
  logic stall_q = 1'b0, stall_last = 1'b0;
  logic [DATA_W-1:0] stall_data = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: sample mid-cycle what will happen at the next rising edge.
  always @(negedge clk) begin
    logic acc;
    logic [DATA_W-1:0] w;
    if (!rst) begin
      exp_q.delete();
      beats = 0; frames = 0; stall_q = 1'b0; pop_pend = 1'b0;
    end else begin
      acc = bus.m_valid && bus.m_ready;
      if (stall_q) begin
        chk("stall_valid", 32'(bus.m_valid), 32'd1);
        chk("stall_data", 32'(bus.m_data), 32'(stall_data));
        chk("stall_last", 32'(bus.m_last), 32'(stall_last));
      end
      chk("frames_done", 32'(frames_done), 32'(frames % (1 << CNT_W)));
      pop_pend = bus.fifo_pop;
      if (bus.fifo_pop) begin
        pops++;
        if (fifo_q.size() == 0) chk("pop_on_empty", 32'd1, 32'd0);
        else exp_q.push_back(fifo_q[0]);
      end
      chk("credit", 32'((exp_q.size() - int'(acc)) <= 2), 32'd1);
      if (bus.m_valid) begin
        chk("m_last", 32'(bus.m_last), 32'((beats % BL) == BL - 1));
`ifdef FIFO_RD_PARITY_EN
        chk("m_par", 32'(bus.m_par), 32'(^bus.m_data));
`endif
      end
      if (acc) begin
        if (exp_q.size() == 0) chk("spurious_beat", 32'd1, 32'd0);
        else begin
          w = exp_q.pop_front();
          chk("m_data", 32'(bus.m_data), 32'(w));
        end
        acc_data.push_back(bus.m_data);
        acc_last.push_back(bus.m_last);
        if ((beats % BL) == BL - 1) frames++;
        beats++;
        n_acc++;
      end
      stall_q    = bus.m_valid && !bus.m_ready;
      stall_data = bus.m_data;
      stall_last = bus.m_last;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [DATA_W-1:0] w);
    push_pend.push_back(w);
  endtask

  task automatic wait_acc(input int target, input int bound);
    int n = 0;
    while (n_acc < target && n < bound) begin step(); n++; end
    if (n_acc < target) chk("timeout_acc", 32'(n_acc), 32'(target));
  endtask

  task automatic wait_pops(input int target, input int bound);
    int n = 0;
    while (pops < target && n < bound) begin step(); n++; end
    if (pops < target) chk("timeout_pops", 32'(pops), 32'(target));
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    step();
    while (busy && n < bound) begin step(); n++; end
    if (busy) chk("timeout_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    int base, t1, t8, f0, p0, n;
    // Reset state.
    repeat (3) step();
    chk("rst_valid", 32'(bus.m_valid), 32'd0);
    chk("rst_data", 32'(bus.m_data), 32'd0);
    chk("rst_last", 32'(bus.m_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_frames", 32'(frames_done), 32'd0);
    chk("rst_pop", 32'(bus.fifo_pop), 32'd0);
    rst = 1'b1;

    // Full-rate drain of two frames.
    for (int i = 0; i < 8; i++) push(8'(8'h11 + i));
    step(); step();
    acc_data.delete(); acc_last.delete();
    base = n_acc; t1 = -1; t8 = -1;
    enable = 1'b1; m_ready = 1'b1;
    n = 0;
    while (n_acc < base + 8 && n < 40) begin
      step(); n++;
      if (t1 < 0 && n_acc >= base + 1) t1 = cyc;
      if (n_acc >= base + 8) t8 = cyc;
    end
    chk("t1_count", 32'(n_acc - base), 32'd8);
    chk("t1_rate", 32'(t8 - t1), 32'd7);
    for (int i = 0; i < 8 && i < acc_data.size(); i++) begin
      chk("t1_data", 32'(acc_data[i]), 32'(8'h11 + i));
      chk("t1_last", 32'(acc_last[i]), 32'(i == 3 || i == 7));
    end
    step();
    chk("t1_frames", 32'(frames_done), 32'd2);

    // Backpressure toggling every cycle.
    for (int i = 0; i < 8; i++) push(8'(8'h11 + i));
    base = n_acc; f0 = frames; n = 0;
    while (n_acc < base + 8 && n < 80) begin m_ready = ~m_ready; step(); n++; end
    chk("t2_count", 32'(n_acc - base), 32'd8);
    m_ready = 1'b1; step();
    chk("t2_frames", 32'(frames_done), 32'(f0 + 2));

    // FIFO runs dry mid-frame, then refills.
    f0 = frames;
    push(8'h21); push(8'h22);
    repeat (10) step();
    chk("t3_valid_drop", 32'(bus.m_valid), 32'd0);
    chk("t3_busy", 32'(busy), 32'd1);
    acc_data.delete(); acc_last.delete();
    push(8'h23); push(8'h24);
    base = n_acc;
    wait_acc(base + 2, 30);
    step();
    if (acc_data.size() >= 2) begin
      chk("t3_last_data", 32'(acc_data[1]), 32'h24);
      chk("t3_last_flag", 32'(acc_last[1]), 32'd1);
    end else chk("t3_beats", 32'(acc_data.size()), 32'd2);
    chk("t3_frames", 32'(frames_done), 32'(f0 + 1));

    // enable drops after two words of a frame were issued.
    enable = 1'b0;
    wait_idle(40);
    for (int i = 0; i < 10; i++) push(8'(8'h40 + i));
    step(); step();
    m_ready = 1'b0; enable = 1'b1; p0 = pops; f0 = frames;
    wait_pops(p0 + 2, 20);
    enable = 1'b0;
    step(); m_ready = 1'b1;
    wait_idle(60);
    chk("t4_pops", 32'(pops - p0), 32'd4);
    chk("t4_left", 32'(fifo_q.size()), 32'd6);
    chk("t4_frames", 32'(frames_done), 32'(f0 + 1));
    chk("t4_busy", 32'(busy), 32'd0);

    // Async reset with a word on the output and one in flight.
    m_ready = 1'b0; enable = 1'b1; p0 = pops;
    wait_pops(p0 + 2, 20);
    chk("t5_pre_valid", 32'(bus.m_valid), 32'd1);
    rst = 1'b0; #1;
    chk("t5_valid", 32'(bus.m_valid), 32'd0);
    chk("t5_frames", 32'(frames_done), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    step(); step();
    rst = 1'b1; m_ready = 1'b1;
    base = n_acc;
    wait_acc(base + 4, 40);
    step();
    chk("t5_frame_after", 32'(frames_done), 32'd1);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) == 0) push(8'($urandom));
      m_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 24) == 0) enable = ~enable;
      step();
    end
    for (int i = 0; i < BL; i++) push(8'($urandom));
    enable = 1'b0; m_ready = 1'b1;
    wait_idle(200);
    chk("rnd_boundary", 32'(beats % BL), 32'd0);
    chk("rnd_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
